// File: rtl/cpu_core.sv
// cpu_core: 8-bit multi-cycle CPU with internal ROM, 4 registers, zero flag, LED port and UART TX
module cpu_core #(
   parameter int    CE_MAX    = 2,
   parameter int    BAUD_DIV  = 868,
   parameter string PROG_FILE = "program",
   parameter int    MEM_DEPTH = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic rxd,
   output logic txd,
   output logic led_0,
   output logic led_1,
   output logic led_2,
   output logic led_3,
   output logic led_4
);
   localparam int CW = $clog2(CE_MAX + 1);
   localparam int BW = $clog2(BAUD_DIV + 1);
   typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;
   state_t state, state_d;
   logic [7:0] core_program_counter, core_program_counter_d;
   logic [15:0] core_current_instruction, core_current_instruction_d;
   logic [0:3][7:0] core_registers, core_registers_d;
   logic [3:0] opcode_q, opcode_d;
   logic [1:0] rd_q, rd_d, rs_q, rs_d;
   logic [7:0] imm_q, imm_d;
   logic z_q, z_d;
   logic [4:0] led_q, led_d;
   logic [CW-1:0] ce_cnt_q, ce_cnt_d;
   logic cpu_ce;
   logic tx_load;
   logic tx_busy_q, tx_busy_d;
   logic [9:0] tx_shift_q, tx_shift_d;
   logic [3:0] tx_bit_q, tx_bit_d;
   logic [BW-1:0] tx_baud_q, tx_baud_d;
   logic rxd_meta_q, rxd_sync_unused_q;
   logic [15:0] rom [MEM_DEPTH];
   logic [15:0] rom_word;
   logic [7:0] ra, rb, alu;
   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) rom[i] = '0;
   end
   assign rom_word = (int'(core_program_counter) < MEM_DEPTH) ? rom[core_program_counter] : '0;
   assign cpu_ce = ce_cnt_q == CW'(CE_MAX - 1);
   assign ce_cnt_d = cpu_ce ? '0 : ce_cnt_q + CW'(1);
   assign ra = core_registers[rd_q];
   assign rb = core_registers[rs_q];
   assign alu = opcode_q == 4'h3 ? ra + rb :
                opcode_q == 4'h4 ? ra - rb :
                opcode_q == 4'h5 ? ra & rb :
                opcode_q == 4'h6 ? ra | rb :
                opcode_q == 4'h7 ? ra ^ rb : ra + imm_q;
   always_comb begin
      state_d = state;
      core_program_counter_d = core_program_counter;
      core_current_instruction_d = core_current_instruction;
      core_registers_d = core_registers;
      opcode_d = opcode_q;
      rd_d = rd_q;
      rs_d = rs_q;
      imm_d = imm_q;
      z_d = z_q;
      led_d = led_q;
      tx_load = 1'b0;
      if (cpu_ce) begin
         case (state)
            FETCH: begin
               core_current_instruction_d = rom_word;
               state_d = DECODE;
            end
            DECODE: begin
               opcode_d = core_current_instruction[15:12];
               rd_d = core_current_instruction[11:10];
               rs_d = core_current_instruction[9:8];
               imm_d = core_current_instruction[7:0];
               state_d = EXEC;
            end
            EXEC: begin
               state_d = FETCH;
               core_program_counter_d = core_program_counter + 8'd1;
               case (opcode_q)
                  4'h1: core_registers_d[rd_q] = imm_q;
                  4'h2: core_registers_d[rd_q] = rb;
                  4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                     core_registers_d[rd_q] = alu;
                     z_d = alu == 8'd0;
                  end
                  4'h9: core_program_counter_d = imm_q;
                  4'hA: core_program_counter_d = z_q ? imm_q : core_program_counter + 8'd1;
                  4'hB: core_program_counter_d = z_q ? core_program_counter + 8'd1 : imm_q;
                  4'hC: begin
                     tx_load = !tx_busy_q;
                     state_d = tx_busy_q ? EXEC : FETCH;
                     core_program_counter_d = tx_busy_q ? core_program_counter : core_program_counter + 8'd1;
                  end
                  4'hD: led_d = imm_q[4:0];
                  4'hE, 4'hF: begin
                     state_d = HALT;
                     core_program_counter_d = core_program_counter;
                  end
                  default: ;
               endcase
            end
            HALT: ;
         endcase
      end
   end
   always_comb begin
      tx_busy_d = tx_busy_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d = tx_bit_q;
      tx_baud_d = tx_baud_q;
      if (tx_load) begin
         tx_busy_d = 1'b1;
         tx_shift_d = {1'b1, rb, 1'b0};
         tx_bit_d = '0;
         tx_baud_d = '0;
      end else if (tx_busy_q) begin
         tx_baud_d = tx_baud_q == BW'(BAUD_DIV - 1) ? '0 : tx_baud_q + BW'(1);
         if (tx_baud_q == BW'(BAUD_DIV - 1)) begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d = tx_bit_q + 4'd1;
            tx_busy_d = tx_bit_q != 4'd9;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         core_program_counter <= '0;
         core_current_instruction <= '0;
         core_registers <= '0;
         opcode_q <= '0;
         rd_q <= '0;
         rs_q <= '0;
         imm_q <= '0;
         z_q <= 1'b0;
         led_q <= '0;
         ce_cnt_q <= '0;
         tx_busy_q <= 1'b0;
         tx_shift_q <= '1;
         tx_bit_q <= '0;
         tx_baud_q <= '0;
         rxd_meta_q <= 1'b1;
         rxd_sync_unused_q <= 1'b1;
      end else begin
         state <= state_d;
         core_program_counter <= core_program_counter_d;
         core_current_instruction <= core_current_instruction_d;
         core_registers <= core_registers_d;
         opcode_q <= opcode_d;
         rd_q <= rd_d;
         rs_q <= rs_d;
         imm_q <= imm_d;
         z_q <= z_d;
         led_q <= led_d;
         ce_cnt_q <= ce_cnt_d;
         tx_busy_q <= tx_busy_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q <= tx_bit_d;
         tx_baud_q <= tx_baud_d;
         rxd_meta_q <= rxd;
         rxd_sync_unused_q <= rxd_meta_q;
      end
   end
   assign txd = tx_busy_q ? tx_shift_q[0] : 1'b1;
   assign led_0 = led_q[0];
   assign led_1 = led_q[1];
   assign led_2 = led_q[2];
   assign led_3 = led_q[3];
   assign led_4 = led_q[4];
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: scoreboard bench with an ISA-level reference model for cpu_core
module tb_cpu_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rxd = 1'b1;
   logic txd, led_0, led_1, led_2, led_3, led_4;
   logic [4:0] led_v;
   typedef struct packed {
      logic [1:0]  st;
      logic [7:0]  pc;
      logic [31:0] regs;
      logic [4:0]  led;
   } ret_t;
   ret_t ret_q[$];
   logic [7:0] byte_q[$];
   logic [15:0] prog [256];
   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;
   always #5 clk = ~clk;
   assign led_v = {led_4, led_3, led_2, led_1, led_0};
   cpu_core #(.CE_MAX(2), .BAUD_DIV(4), .PROG_FILE(""), .MEM_DEPTH(256)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .txd(txd),
      .led_0(led_0), .led_1(led_1), .led_2(led_2), .led_3(led_3), .led_4(led_4)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic run_model();
      logic [7:0] r [4];
      logic [7:0] pc, nxt, res;
      logic [15:0] w;
      logic [3:0] op;
      logic [1:0] d, s;
      logic [4:0] led;
      logic z;
      bit halt;
      ret_t e;
      r = '{default: 8'h00};
      pc = 8'h00;
      z = 1'b0;
      led = 5'h00;
      for (int n = 0; n < 400; n++) begin
         w = prog[pc];
         op = w[15:12];
         d = w[11:10];
         s = w[9:8];
         nxt = pc + 8'd1;
         halt = 1'b0;
         case (op)
            4'h1: r[d] = w[7:0];
            4'h2: r[d] = r[s];
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
               case (op)
                  4'h3: res = r[d] + r[s];
                  4'h4: res = r[d] - r[s];
                  4'h5: res = r[d] & r[s];
                  4'h6: res = r[d] | r[s];
                  4'h7: res = r[d] ^ r[s];
                  default: res = r[d] + w[7:0];
               endcase
               r[d] = res;
               z = res == 8'h00;
            end
            4'h9: nxt = w[7:0];
            4'hA: if (z) nxt = w[7:0];
            4'hB: if (!z) nxt = w[7:0];
            4'hC: byte_q.push_back(r[s]);
            4'hD: led = w[4:0];
            4'hE, 4'hF: begin
               halt = 1'b1;
               nxt = pc;
            end
            default: ;
         endcase
         pc = nxt;
         e.st = halt ? 2'd3 : 2'd0;
         e.pc = pc;
         e.regs = {r[0], r[1], r[2], r[3]};
         e.led = led;
         ret_q.push_back(e);
         if (halt) break;
      end
   endtask
   task automatic begin_prog(input bit en);
      reset = 1'b1;
      check_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ret_q.delete();
      byte_q.delete();
      for (int i = 0; i < 256; i++) dut.rom[i] = prog[i];
      if (en) run_model();
      check_en = en;
   endtask
   task automatic release_rst();
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic step6();
      repeat (6) @(posedge clk);
      #1;
   endtask
   task automatic wait_halt(input string name);
      int n;
      n = 0;
      while (!(dut.state == 2'd3 && ret_q.size() == 0 && byte_q.size() == 0) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (n >= 5000) begin
         fails++;
         $display("FAIL %s: timeout, state %0d, %0d retires and %0d bytes outstanding, expected halt with none",
                  name, dut.state, ret_q.size(), byte_q.size());
      end
   endtask
   initial begin
      logic [1:0] prev;
      ret_t a, e;
      prev = 2'd0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) prev = 2'd0;
         else begin
            if (check_en && prev == 2'd2 && dut.state != 2'd2) begin
               a.st = dut.state;
               a.pc = dut.core_program_counter;
               a.regs = dut.core_registers;
               a.led = led_v;
               tests++;
               if (ret_q.size() == 0) begin
                  fails++;
                  $display("FAIL retire: got unexpected retire %h, expected none", a);
               end else begin
                  e = ret_q.pop_front();
                  if (a !== e) begin
                     fails++;
                     $display("FAIL retire: got %h, expected %h", a, e);
                  end
               end
            end
            prev = dut.state;
         end
      end
   end
   initial begin
      logic [9:0] f;
      logic [7:0] e;
      bit ab;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && txd === 1'b0) begin
            ab = 1'b0;
            for (int k = 0; k < 10; k++) begin
               repeat (k == 0 ? 2 : 4) @(posedge clk);
               #1;
               if (reset) begin
                  ab = 1'b1;
                  break;
               end
               f[k] = txd;
            end
            if (!ab) begin
               tests++;
               if (byte_q.size() == 0) begin
                  fails++;
                  $display("FAIL uart: got unexpected frame %b, expected none", f);
               end else begin
                  e = byte_q.pop_front();
                  if (f !== {1'b1, e, 1'b0}) begin
                     fails++;
                     $display("FAIL uart: got frame %b, expected %b", f, {1'b1, e, 1'b0});
                  end
               end
            end
         end
      end
   end
   initial begin
      logic [3:0] op;
      logic [7:0] im;
      prog = '{default: 16'h0000};
      begin_prog(1'b0);
      check("rst state", 32'(dut.state), 0);
      check("rst pc", dut.core_program_counter, 0);
      check("rst r0", dut.core_registers[0], 0);
      check("rst txd", txd, 1);
      check("rst led", led_v, 0);
      release_rst();
      repeat (5) @(posedge clk);
      #1;
      check("pc after 5 clk", dut.core_program_counter, 8'h00);
      @(posedge clk);
      #1;
      check("pc after 6 clk", dut.core_program_counter, 8'h01);
      prog = '{default: 16'h0000};
      prog[0] = 16'h1005;
      prog[1] = 16'h8003;
      prog[2] = 16'h4000;
      prog[3] = 16'hE000;
      begin_prog(1'b1);
      release_rst();
      step6();
      check("ldi r0", dut.core_registers[0], 8'h05);
      step6();
      check("addi r0", dut.core_registers[0], 8'h08);
      step6();
      check("sub r0", dut.core_registers[0], 8'h00);
      check("sub pc", dut.core_program_counter, 8'h03);
      wait_halt("arith halt");
      check("arith pc", dut.core_program_counter, 8'h03);
      prog = '{default: 16'h0000};
      prog[0] = 16'h1402;
      prog[1] = 16'h84FF;
      prog[2] = 16'hB001;
      prog[3] = 16'hE000;
      begin_prog(1'b1);
      release_rst();
      repeat (36) @(posedge clk);
      #1;
      check("loop state", 32'(dut.state), 3);
      check("loop r1", dut.core_registers[1], 8'h00);
      check("loop pc", dut.core_program_counter, 8'h03);
      repeat (120) @(posedge clk);
      #1;
      check("halt state held", 32'(dut.state), 3);
      check("halt pc held", dut.core_program_counter, 8'h03);
      prog = '{default: 16'h0000};
      prog[0] = 16'hD015;
      prog[1] = 16'hE000;
      begin_prog(1'b1);
      release_rst();
      step6();
      check("led port", led_v, 5'h15);
      wait_halt("led halt");
      prog = '{default: 16'h0000};
      prog[0] = 16'h18A5;
      prog[1] = 16'hC200;
      prog[2] = 16'hC200;
      prog[3] = 16'hE000;
      begin_prog(1'b1);
      release_rst();
      repeat (30) @(posedge clk);
      #1;
      check("out stall state", 32'(dut.state), 2);
      check("out stall pc", dut.core_program_counter, 8'h02);
      wait_halt("uart halt");
      prog = '{default: 16'h0000};
      prog[0] = 16'h18A5;
      prog[1] = 16'hC200;
      prog[2] = 16'hE000;
      begin_prog(1'b1);
      release_rst();
      repeat (30) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midframe txd", txd, 1);
      check("midframe pc", dut.core_program_counter, 8'h00);
      check("midframe state", 32'(dut.state), 0);
      check("midframe r2", dut.core_registers[2], 8'h00);
      begin_prog(1'b1);
      release_rst();
      step6();
      check("restart r2", dut.core_registers[2], 8'hA5);
      wait_halt("restart halt");
      for (int t = 0; t < 25; t++) begin
         prog = '{default: 16'h0000};
         for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 15));
            im = (op inside {4'h9, 4'hA, 4'hB}) ? 8'($urandom_range(i + 1, 20)) : 8'($urandom);
            prog[i] = {op, 2'($urandom), 2'($urandom), im};
         end
         prog[20] = 16'hE000;
         begin_prog(1'b1);
         release_rst();
         wait_halt("random halt");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
